// File: rtl/apb_i2c_regif.sv
// APB3 slave register interface for the I2C core: TX/RX FIFO data ports plus CONFIG/TIMEOUT registers.
// Latency: zero wait states. PREADY, PRDATA, PSLVERR, WR_ENA and RD_ENA are combinational; the registers update on the closing edge.
// Backpressure: none is applied to APB. A read of an empty RX FIFO, an unmapped address, or a core ERROR is reported on PSLVERR.
module apb_i2c_regif (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] WRITE_DATA_ON_TX,
  output logic        WR_ENA,
  input  logic [31:0] READ_DATA_ON_RX,
  output logic        RD_ENA,
  input  logic        TX_EMPTY,
  input  logic        RX_EMPTY,
  input  logic        ERROR,
  output logic        INT_TX,
  output logic        INT_RX,
  output logic [13:0] INTERNAL_I2C_REGISTER_CONFIG,
  output logic [13:0] INTERNAL_I2C_REGISTER_TIMEOUT
);

  localparam logic [31:0] ADDR_TX  = 32'h0000_0000;
  localparam logic [31:0] ADDR_RX  = 32'h0000_0004;
  localparam logic [31:0] ADDR_CFG = 32'h0000_0008;
  localparam logic [31:0] ADDR_TMO = 32'h0000_000C;

  // PRESETn is active-high despite its name; it gates every access.
  logic        acc;
  logic        wr_acc;
  logic        rd_acc;
  logic        hit_tx, hit_rx, hit_cfg, hit_tmo, unmapped;
  logic [31:0] tx_dat_d, tx_dat_q;
  logic [13:0] cfg_d, cfg_q;
  logic [13:0] tmo_d, tmo_q;

  assign acc      = PSELx & PENABLE & ~PRESETn;
  assign wr_acc   = acc & PWRITE;
  assign rd_acc   = acc & ~PWRITE;
  assign hit_tx   = (PADDR == ADDR_TX);
  assign hit_rx   = (PADDR == ADDR_RX);
  assign hit_cfg  = (PADDR == ADDR_CFG);
  assign hit_tmo  = (PADDR == ADDR_TMO);
  assign unmapped = ~(hit_tx | hit_rx | hit_cfg | hit_tmo);

  // Bus response, FIFO strobes and read mux. Everything is zero outside an access.
  always_comb begin
    PREADY  = acc;
    WR_ENA  = wr_acc & hit_tx;
    RD_ENA  = rd_acc & hit_rx & ~RX_EMPTY;
    PSLVERR = acc & (ERROR | unmapped | (~PWRITE & hit_rx & RX_EMPTY));
    PRDATA  = 32'h0;
    if (rd_acc) begin
      if (hit_rx && !RX_EMPTY) PRDATA = READ_DATA_ON_RX;
      else if (hit_cfg)        PRDATA = {18'h0, cfg_q};
      else if (hit_tmo)        PRDATA = {18'h0, tmo_q};
    end
  end

  // Next-state of the registers: only a write access to their address changes them.
  always_comb begin
    tx_dat_d = tx_dat_q;
    cfg_d    = cfg_q;
    tmo_d    = tmo_q;
    if (wr_acc && hit_tx)  tx_dat_d = PWDATA;
    if (wr_acc && hit_cfg) cfg_d    = PWDATA[13:0];
    if (wr_acc && hit_tmo) tmo_d    = PWDATA[13:0];
  end

  // Register state with synchronous active-high reset.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      tx_dat_q <= 32'h0;
      cfg_q    <= 14'h0;
      tmo_q    <= 14'h0;
    end else begin
      tx_dat_q <= tx_dat_d;
      cfg_q    <= cfg_d;
      tmo_q    <= tmo_d;
    end
  end

  assign WRITE_DATA_ON_TX              = tx_dat_q;
  assign INTERNAL_I2C_REGISTER_CONFIG  = cfg_q;
  assign INTERNAL_I2C_REGISTER_TIMEOUT = tmo_q;
  assign INT_TX                        = TX_EMPTY & ~PRESETn;
  assign INT_RX                        = ~RX_EMPTY & ~PRESETn;

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Bench for apb_i2c_regif: directed APB vectors with hand-computed expected responses.
// Each stimulus cycle pushes its expected output set to a queue; a monitor pops and compares it.
// The monitor samples on the falling clock edge while stimulus is driven just after the rising edge.
module tb_apb_i2c_regif;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA, WRITE_DATA_ON_TX, READ_DATA_ON_RX;
  logic        PREADY, PSLVERR, WR_ENA, RD_ENA, TX_EMPTY, RX_EMPTY, ERROR, INT_TX, INT_RX;
  logic [13:0] cfg, tmo;

  apb_i2c_regif dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX), .WR_ENA(WR_ENA), .READ_DATA_ON_RX(READ_DATA_ON_RX),
    .RD_ENA(RD_ENA), .TX_EMPTY(TX_EMPTY), .RX_EMPTY(RX_EMPTY), .ERROR(ERROR),
    .INT_TX(INT_TX), .INT_RX(INT_RX),
    .INTERNAL_I2C_REGISTER_CONFIG(cfg), .INTERNAL_I2C_REGISTER_TIMEOUT(tmo)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        wr_ena;
    logic        rd_ena;
    logic        int_tx;
    logic        int_rx;
    logic [31:0] tx;
    logic [13:0] cfg;
    logic [13:0] tmo;
  } exp_t;

  exp_t exp_q[$];
  logic obs_vld = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   vec = 0;

  function automatic exp_t mk(input logic [31:0] prdata, input logic pready, input logic pslverr,
                              input logic wr, input logic rd, input logic itx, input logic irx,
                              input logic [31:0] tx, input logic [13:0] c, input logic [13:0] t);
    exp_t e;
    e.prdata = prdata; e.pready = pready; e.pslverr = pslverr; e.wr_ena = wr; e.rd_ena = rd;
    e.int_tx = itx; e.int_rx = irx; e.tx = tx; e.cfg = c; e.tmo = t;
    return e;
  endfunction

  task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %h expected %h", v, name, act, exp);
    end
  endtask

  // Monitor: whenever the DUT completes a transfer or a vector is under observation, pop and compare.
  initial begin
    exp_t e;
    int   v;
    v = 0;
    forever begin
      @(negedge PCLK);
      if (obs_vld || PREADY === 1'b1) begin
        v++;
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL vec%0d unexpected_pready: got PREADY=%b with no expected response", v, PREADY);
        end else begin
          e = exp_q.pop_front();
          chk("PRDATA",  v, PRDATA,                  e.prdata);
          chk("PREADY",  v, {31'h0, PREADY},         {31'h0, e.pready});
          chk("PSLVERR", v, {31'h0, PSLVERR},        {31'h0, e.pslverr});
          chk("WR_ENA",  v, {31'h0, WR_ENA},         {31'h0, e.wr_ena});
          chk("RD_ENA",  v, {31'h0, RD_ENA},         {31'h0, e.rd_ena});
          chk("INT_TX",  v, {31'h0, INT_TX},         {31'h0, e.int_tx});
          chk("INT_RX",  v, {31'h0, INT_RX},         {31'h0, e.int_rx});
          chk("TX_DATA", v, WRITE_DATA_ON_TX,        e.tx);
          chk("CONFIG",  v, {18'h0, cfg},            {18'h0, e.cfg});
          chk("TIMEOUT", v, {18'h0, tmo},            {18'h0, e.tmo});
        end
      end
    end
  end

  task automatic drv(input logic rst, input logic sel, input logic en, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rxd,
                     input logic txe, input logic rxe, input logic err);
    PRESETn = rst; PSELx = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    READ_DATA_ON_RX = rxd; TX_EMPTY = txe; RX_EMPTY = rxe; ERROR = err;
  endtask

  // Register the expected response for the cycle just driven and advance one clock.
  task automatic step(input exp_t e);
    exp_q.push_back(e);
    obs_vld = 1'b1;
    vec++;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    // First reset edge with a random bus; register outputs are unknown before it, so it is not observed.
    drv(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
        1'($urandom), 1'($urandom), 1'($urandom));
    @(posedge PCLK);
    #1;

    // Reset still asserted with a random bus: all zero.
    drv(1'b1, 1'b1, 1'b1, 1'($urandom), 32'h8, $urandom, $urandom, 1'b1, 1'b0, 1'($urandom));
    step(mk(32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 14'h0, 14'h0));
    // Idle bus out of reset.
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 14'h0, 14'h0));
    // CONFIG write keeps only the low 14 bits, then readback.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h8, 32'hFFFF_ABCD, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 1, 0, 0, 0, 0, 0, 32'h0, 14'h0, 14'h0));
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0000_2BCD, 1, 0, 0, 0, 0, 0, 32'h0, 14'h2BCD, 14'h0));
    // TIMEOUT write and readback.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'hC, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 1, 0, 0, 0, 0, 0, 32'h0, 14'h2BCD, 14'h0));
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0000_1234, 1, 0, 0, 0, 0, 0, 32'h0, 14'h2BCD, 14'h1234));
    // TX push: strobe in the access cycle only, data registered on the edge.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 1, 0, 1, 0, 0, 0, 32'h0, 14'h2BCD, 14'h1234));
    // Setup phase only (PENABLE low): no access, no strobes.
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1111_2222, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 14'h2BCD, 14'h1234));
    // TX push during a core ERROR: still pushes, flags an error.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 1'b1);
    step(mk(32'h0, 1, 1, 1, 0, 0, 0, 32'hDEAD_BEEF, 14'h2BCD, 14'h1234));
    // RX pop with data available; TX FIFO empty raises INT_TX.
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 32'h55AA_00FF, 1'b1, 1'b0, 1'b0);
    step(mk(32'h55AA_00FF, 1, 0, 0, 1, 1, 1, 32'hCAFE_F00D, 14'h2BCD, 14'h1234));
    // RX read while empty: error, no pop, zero data.
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 32'h55AA_00FF, 1'b1, 1'b1, 1'b0);
    step(mk(32'h0, 1, 1, 0, 0, 1, 0, 32'hCAFE_F00D, 14'h2BCD, 14'h1234));
    // Unmapped write and read.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 1, 1, 0, 0, 0, 0, 32'hCAFE_F00D, 14'h2BCD, 14'h1234));
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 1, 1, 0, 0, 0, 0, 32'hCAFE_F00D, 14'h2BCD, 14'h1234));
    // Address matching uses all 32 bits: a CONFIG alias in the upper bits is unmapped.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0008, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 1, 1, 0, 0, 0, 0, 32'hCAFE_F00D, 14'h2BCD, 14'h1234));
    // Write to RX address is ignored without error; read of TX address returns zero.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h0000_3FFF, 32'h0, 1'b0, 1'b0, 1'b0);
    step(mk(32'h0, 1, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 14'h2BCD, 14'h1234));
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0, 1, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 14'h2BCD, 14'h1234));
    // Reset mid-access with TX empty: everything combinational drops to zero.
    drv(1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0000_3FFF, 32'h0, 1'b1, 1'b0, 1'b1);
    step(mk(32'h0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 14'h2BCD, 14'h1234));
    // After that edge the registers are cleared, not loaded by the aborted write.
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(mk(32'h0, 0, 0, 0, 0, 1, 1, 32'h0, 14'h0, 14'h0));
    // CONFIG write with ERROR set: register still written, error flagged.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0000_0155, 32'h0, 1'b0, 1'b1, 1'b1);
    step(mk(32'h0, 1, 1, 0, 0, 0, 0, 32'h0, 14'h0, 14'h0));
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(mk(32'h0000_0155, 1, 0, 0, 0, 0, 0, 32'h0, 14'h155, 14'h0));

    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    obs_vld = 1'b0;
    repeat (3) @(posedge PCLK);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected responses never observed, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation reached time limit after %0d vectors", vec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_i2c_regif.md
Name: apb_i2c_regif

Overview:
- APB3 slave register interface sitting between the system APB bus and the I2C core.
- Pushes write data into the I2C TX FIFO and pops received data from the RX FIFO.
- Holds the 14-bit I2C configuration and timeout registers.
- Exports FIFO-status interrupts and a bus error response.

Parameters:
- ADDR_TX, 32'h0000_0000, TX FIFO data register (write-only).
- ADDR_RX, 32'h0000_0004, RX FIFO data register (read-only).
- ADDR_CFG, 32'h0000_0008, CONFIG register (R/W, 14 bits).
- ADDR_TMO, 32'h0000_000C, TIMEOUT register (R/W, 14 bits).

Ports:
- PCLK  in  1  clock; all state updates on rising edge.
- PRESETn  in  1  reset; synchronous, active-high (asserted when 1), despite the name.
- PSELx  in  1  slave select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  32  byte address, full 32-bit compare.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- WRITE_DATA_ON_TX  out  32  data to TX FIFO.
- WR_ENA  out  1  TX FIFO push strobe.
- READ_DATA_ON_RX  in  32  RX FIFO head data.
- RD_ENA  out  1  RX FIFO pop strobe.
- TX_EMPTY  in  1  TX FIFO empty.
- RX_EMPTY  in  1  RX FIFO empty.
- ERROR  in  1  I2C core error flag.
- INT_TX  out  1  TX interrupt.
- INT_RX  out  1  RX interrupt.
- INTERNAL_I2C_REGISTER_CONFIG  out  14  config register.
- INTERNAL_I2C_REGISTER_TIMEOUT  out  14  timeout register.

Behaviour:
- Access: ACC = PSELx & PENABLE & ~PRESETn. Every access completes with zero wait states. No setup-phase check is made; PENABLE high with PSELx high in any cycle counts as an access.
- PREADY = ACC (combinational).
- Write decode (ACC & PWRITE):
  - ADDR_TX: WR_ENA=1 combinationally in that cycle. On the same edge, WRITE_DATA_ON_TX <= PWDATA (registered, holds until next TX write). Each access cycle with ACC high is one push.
  - ADDR_CFG: CONFIG <= PWDATA[13:0] on the edge.
  - ADDR_TMO: TIMEOUT <= PWDATA[13:0] on the edge.
  - ADDR_RX: ignored, no error.
- Read decode (ACC & ~PWRITE), PRDATA combinational:
  - ADDR_RX with RX_EMPTY=0: PRDATA=READ_DATA_ON_RX and RD_ENA=1. The FIFO pops on the edge that ends the access.
  - ADDR_RX with RX_EMPTY=1: PRDATA=0, RD_ENA=0, PSLVERR=1.
  - ADDR_CFG: PRDATA={18'b0, CONFIG}.
  - ADDR_TMO: PRDATA={18'b0, TIMEOUT}.
  - ADDR_TX: PRDATA=0, no error.
- PRDATA=0 whenever there is no read access.
- PSLVERR = ACC & (ERROR | unmapped PADDR | RX read while RX_EMPTY). An unmapped address has no side effects.
- ERROR during a TX write still pushes (WR_ENA=1) and flags PSLVERR.
- INT_TX = TX_EMPTY & ~PRESETn. INT_RX = ~RX_EMPTY & ~PRESETn (data available).
- Reset (PRESETn=1 at a rising edge):
  - CONFIG=0, TIMEOUT=0, WRITE_DATA_ON_TX=0.
  - While PRESETn=1, all combinational outputs are 0: PREADY, WR_ENA, RD_ENA, PSLVERR, INT_TX, INT_RX, PRDATA.
  - Reset asserted mid-access aborts the access: no register update, no push or pop.
- Inputs X/undefined before the first reset: outputs are don't-care until the first reset edge.

Test Plan:
- Reset: PRESETn=1 for 1 edge with random bus -> CONFIG=0, TIMEOUT=0, WRITE_DATA_ON_TX=0, all strobes/PREADY/PSLVERR/PRDATA/INT_* =0.
- Config write/readback:
  - Write PADDR=8, PWDATA=32'hFFFF_ABCD -> CONFIG=14'h2BCD; read addr 8 -> PRDATA=32'h0000_2BCD, PREADY=1, PSLVERR=0.
  - Same for addr C with 32'h0000_1234 -> TIMEOUT=14'h1234.
- TX push: write addr 0, PWDATA=32'hDEADBEEF, ACC for 1 cycle -> WR_ENA=1 that cycle only, WRITE_DATA_ON_TX=32'hDEADBEEF after the edge. With ERROR=1 -> PSLVERR=1 and the push still occurs.
- RX pop:
  - RX_EMPTY=0, READ_DATA_ON_RX=32'h55AA_00FF, read addr 4 -> PRDATA=32'h55AA00FF, RD_ENA=1, INT_RX=1.
  - RX_EMPTY=1 -> RD_ENA=0, PRDATA=0, PSLVERR=1, INT_RX=0.
- Unmapped/idle: PADDR=32'h10 access -> PSLVERR=1, no register change, PRDATA=0. PSELx=1, PENABLE=0 -> PREADY=0, no strobes.
- Interrupts: TX_EMPTY=1 -> INT_TX=1. TX_EMPTY=0 -> INT_TX=0. PRESETn=1 mid-access with TX_EMPTY=1 -> INT_TX=0, PREADY=0, CONFIG unchanged by the pending write.
